lfsr_share_ctrl: RTL and testbench



---
 rtl/lfsr_share_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lfsr_share_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_share_ctrl.sv
// Shares one XNOR LFSR between two round-robin requesters. Each grant is preceded by
// STEPS LFSR advances so consecutive words handed out are decorrelated.

module lfsr_share_ctrl_lfsr #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                seed_load_i,
  input  logic [NUM_BITS-1:0] seed_i,
  output logic [NUM_BITS-1:0] data_o
);

  // Tap positions (1-indexed t maps to bit t-1) for maximal-length XNOR sequences.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    unique case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [31:0]         TapMask32 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TapMask   = TapMask32[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      if (seed_load_i) begin
        lfsr_d = seed_i;
      end else begin
        lfsr_d = {lfsr_q[NUM_BITS-2:0], ~^(lfsr_q & TapMask)};
      end
    end
  end

  // No reset: the controller always seeds the register before it is used.
  always_ff @(posedge clk_i) begin
    lfsr_q <= lfsr_d;
  end

  assign data_o = lfsr_q;

endmodule

module lfsr_share_ctrl #(
  parameter int unsigned          NUM_BITS = 32,
  parameter int unsigned          STEPS    = 4,
  parameter logic [NUM_BITS-1:0]  SEED     = '0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [1:0]          i_Req,
  input  logic                i_Reseed,
  input  logic [NUM_BITS-1:0] i_Seed,
  output logic [1:0]          o_Gnt,
  output logic [NUM_BITS-1:0] o_Data,
  output logic                o_Busy,
  output logic                o_Seed_Err
);

  typedef enum logic [1:0] {StSeed, StIdle, StStep, StGnt} state_e;

  localparam logic [7:0] LastStep = 8'(STEPS - 1);

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                seed_err_q, seed_err_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                winner_q, winner_d;
  logic [7:0]          step_cnt_q, step_cnt_d;

  logic                lfsr_en;
  logic                lfsr_load;
  logic [NUM_BITS-1:0] lfsr_data;

  lfsr_share_ctrl_lfsr #(
    .NUM_BITS (NUM_BITS)
  ) u_lfsr (
    .clk_i       (i_Clk),
    .en_i        (lfsr_en),
    .seed_load_i (lfsr_load),
    .seed_i      (seed_q),
    .data_o      (lfsr_data)
  );

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    data_d     = data_q;
    gnt_d      = 2'b00;
    seed_err_d = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    step_cnt_d = step_cnt_q;
    lfsr_en    = 1'b0;
    lfsr_load  = 1'b0;

    unique case (state_q)
      StSeed: begin
        lfsr_en   = 1'b1;
        lfsr_load = 1'b1;
        state_d   = StIdle;
      end
      StIdle: begin
        if (i_Reseed) begin
          // All ones is the XNOR lockup state; fall back to the default seed.
          if (&i_Seed) begin
            seed_d     = SEED;
            seed_err_d = 1'b1;
          end else begin
            seed_d = i_Seed;
          end
          state_d = StSeed;
        end else if (|i_Req) begin
          winner_d   = (i_Req == 2'b11) ? rr_ptr_q : i_Req[1];
          step_cnt_d = '0;
          state_d    = StStep;
        end
      end
      StStep: begin
        lfsr_en    = 1'b1;
        step_cnt_d = step_cnt_q + 8'd1;
        if (step_cnt_q == LastStep) begin
          state_d = StGnt;
        end
      end
      StGnt: begin
        gnt_d    = winner_q ? 2'b10 : 2'b01;
        data_d   = lfsr_data;
        rr_ptr_d = ~winner_q;
        state_d  = StIdle;
      end
      default: state_d = StSeed;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= StSeed;
      seed_q     <= SEED;
      data_q     <= '0;
      gnt_q      <= 2'b00;
      seed_err_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
      winner_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      seed_err_q <= seed_err_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign o_Gnt      = gnt_q;
  assign o_Data     = data_q;
  assign o_Seed_Err = seed_err_q;
  assign o_Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Bench for lfsr_share_ctrl: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed grant timing and data words.

module tb_lfsr_share_ctrl;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, reseed;
  logic [1:0] req;
  logic [7:0] seed;
  logic [1:0] gnt;
  logic [7:0] data;
  logic       busy, serr;

  logic       b_rst;
  logic [1:0] b_req;
  logic [1:0] b_gnt;
  logic [7:0] b_data;
  logic       b_busy, b_serr;

  int checks = 0;
  int errors = 0;

  lfsr_share_ctrl #(
    .NUM_BITS (8),
    .STEPS    (4),
    .SEED     (8'h00)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Req      (req),
    .i_Reseed   (reseed),
    .i_Seed     (seed),
    .o_Gnt      (gnt),
    .o_Data     (data),
    .o_Busy     (busy),
    .o_Seed_Err (serr)
  );

  lfsr_share_ctrl #(
    .NUM_BITS (8),
    .STEPS    (1),
    .SEED     (8'h00)
  ) dut_b (
    .i_Clk      (clk),
    .i_Rst      (b_rst),
    .i_Req      (b_req),
    .i_Reseed   (1'b0),
    .i_Seed     (8'h00),
    .o_Gnt      (b_gnt),
    .o_Data     (b_data),
    .o_Busy     (b_busy),
    .o_Seed_Err (b_serr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 8-bit XNOR LFSR with taps 8,6,5,4, advanced n times.
  function automatic logic [7:0] adv(input logic [7:0] x, input int n);
    logic [7:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
    return v;
  endfunction

  // Transaction model: an accepted request is granted S+1 edges later with the word
  // S advances beyond the value held at acceptance.
  typedef struct packed {
    logic       valid;
    logic       seeding;
    logic [7:0] left;
    logic       win;
    logic       rr;
    logic [7:0] sd;
    logic [7:0] lf;
    logic [7:0] dt;
    logic [1:0] g;
    logic       er;
  } model_t;

  model_t m = '0;

  function automatic model_t model_next(input model_t c, input logic r, input logic [1:0] rq,
                                        input logic rs, input logic [7:0] sv);
    model_t n;
    n    = c;
    n.g  = 2'b00;
    n.er = 1'b0;
    if (r) begin
      n.valid   = 1'b1;
      n.seeding = 1'b1;
      n.left    = 8'd0;
      n.rr      = 1'b0;
      n.sd      = 8'h00;
      n.dt      = 8'h00;
    end else if (c.seeding) begin
      n.lf      = c.sd;
      n.seeding = 1'b0;
    end else if (c.left != 8'd0) begin
      n.left = c.left - 8'd1;
      if (n.left == 8'd0) begin
        n.lf = adv(c.lf, S);
        n.dt = n.lf;
        n.g  = c.win ? 2'b10 : 2'b01;
        n.rr = ~c.win;
      end
    end else if (rs) begin
      n.er      = (sv == 8'hFF);
      n.sd      = n.er ? 8'h00 : sv;
      n.seeding = 1'b1;
    end else if (rq != 2'b00) begin
      n.win  = (rq == 2'b11) ? c.rr : rq[1];
      n.left = 8'(S + 1);
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, req, reseed, seed);

  always @(negedge clk) begin
    if (m.valid) begin
      chk("cyc_gnt", gnt, m.g);
      chk("cyc_data", data, m.dt);
      chk("cyc_busy", busy, m.seeding || (m.left != 8'd0));
      chk("cyc_seed_err", serr, m.er);
    end
  end

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    rst = 1'b1; req = 2'b00; reseed = 1'b0; seed = 8'h00;
    b_rst = 1'b1; b_req = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b1);
    chk("rst_seed_err", serr, 1'b0);
    rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Single requester from reset seed.
    req = 2'b01;
    @(negedge clk);
    chk("t1_busy", busy, 1'b1);
    wait_gnt(n);
    chk("t1_lat", n + 1, 6);
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_data", data, 8'h0F);
    req = 2'b00;
    @(negedge clk);
    chk("t1_idle", busy, 1'b0);

    // Continue the sequence: 0x0F -> 1E, 3D, 7A, F4.
    req = 2'b01;
    wait_gnt(n);
    chk("t2_lat", n, 6);
    chk("t2_data", data, 8'hF4);
    req = 2'b00;

    // Both held from reset: strict alternation every S+2 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(n);
      chk("t3_lat", n, (i == 0) ? 7 : 6);
      chk("t3_gnt", gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i == 0) chk("t3_data0", data, 8'h0F);
    end
    req = 2'b00;

    // Illegal all-ones seed with a simultaneous request.
    @(negedge clk);
    reseed = 1'b1; seed = 8'hFF; req = 2'b10;
    @(negedge clk);
    chk("t4_seed_err", serr, 1'b1);
    reseed = 1'b0; seed = 8'h00;
    wait_gnt(n);
    chk("t4_lat", n, 7);
    chk("t4_gnt", gnt, 2'b10);
    chk("t4_data", data, 8'h0F);
    req = 2'b00;

    // Reset on the second STEP cycle abandons the grant.
    @(negedge clk);
    req = 2'b01;
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    chk("t5_gnt", gnt, 2'b00);
    chk("t5_data", data, 8'h00);
    chk("t5_busy", busy, 1'b1);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != 2'b00) cnt++;
    end
    chk("t5_no_grant", cnt, 0);
    req = 2'b01;
    wait_gnt(n);
    chk("t5_lat", n, 6);
    chk("t5_regnt", gnt, 2'b01);
    chk("t5_data2", data, 8'h0F);
    req = 2'b00;

    // Request change during STEP does not move the latched winner.
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    req = 2'b10;
    wait_gnt(n);
    chk("t7_lat", n, 5);
    chk("t7_gnt", gnt, 2'b01);
    wait_gnt(n);
    chk("t7_lat2", n, 6);
    chk("t7_gnt2", gnt, 2'b10);
    req = 2'b00;

    // STEPS=1 instance: one advance from seed 0 gives 0x01.
    b_req = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b_gnt == 2'b00 && n < 40);
    chk("t6_lat", n, 3);
    chk("t6_gnt", b_gnt, 2'b01);
    chk("t6_data", b_data, 8'h01);
    b_req = 2'b00;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
